// File: rtl/xs3_bcd_seq.sv
// Sequenced Excess-3 to BCD converter: accepts a packed word, converts one digit
// per clock through a shared digit converter, and returns the packed BCD result.
module xs3_bcd_seq #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic [DIGITS-1:0]     out_err_mask,
   output logic                  out_err,
   output logic                  busy
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] idx;
   logic [W-1:0]  shift_q;
   logic [3:0]    dig_bcd;
   logic          dig_bad;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its peers, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = CONV;
         end
         CONV: begin
            busy = 1'b1;
            if (idx == LAST_IDX) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shared digit converter: always looks at the low nibble of the shift register.
   always_comb begin
      dig_bad = (shift_q[3:0] < 4'd3) || (shift_q[3:0] > 4'd12);
      dig_bcd = dig_bad ? 4'h0 : (shift_q[3:0] - 4'd3);
   end

   // NOTE: the datapath registers are few and small, so all of them are reset;
   // that makes the outputs well defined immediately after an aborted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q      <= '0;
         idx          <= '0;
         out_bcd      <= '0;
         out_err_mask <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_q      <= in_data;
                  idx          <= '0;
                  out_bcd      <= '0;
                  out_err_mask <= '0;
               end
            end
            CONV: begin
               shift_q <= shift_q >> 4;
               // Hold on the last digit instead of wrapping; accept reloads it.
               idx     <= (idx == LAST_IDX) ? idx : idx + 1'b1;
               for (int k = 0; k < DIGITS; k++) begin
                  if (idx == IW'(k)) begin
                     out_bcd[4*k +: 4] <= dig_bcd;
                     out_err_mask[k]   <= dig_bad;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign out_err = |out_err_mask;

endmodule

// File: tb/tb_xs3_bcd_seq.sv
// Randomised scoreboard bench for xs3_bcd_seq: accepted words are modelled and
// queued, and a monitor compares every delivered result against the queue.
module tb_xs3_bcd_seq;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   typedef struct {
      logic [W-1:0]      bcd;
      logic [DIGITS-1:0] mask;
      logic              err;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_data;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_bcd;
   logic [DIGITS-1:0] out_err_mask;
   logic              out_err;
   logic              busy;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   n_acc = 0;
   int   last_acc = -1;
   bit   b2b   = 1'b0;
   bit   rnd_on = 1'b0;
   exp_t exp_q[$];
   int   acc_q[$];

   xs3_bcd_seq #(.DIGITS(DIGITS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bcd      (out_bcd),
      .out_err_mask (out_err_mask),
      .out_err      (out_err),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: each Excess-3 digit e maps to e-3 when 3<=e<=12, else 0 with an error flag.
   function automatic exp_t ref_conv(input logic [W-1:0] w);
      exp_t r;
      r.bcd  = '0;
      r.mask = '0;
      for (int k = 0; k < DIGITS; k++) begin
         int e;
         e = int'((w >> (4 * k)) & W'(15));
         if (e >= 3 && e <= 12) r.bcd = r.bcd | (W'(e - 3) << (4 * k));
         else                   r.mask[k] = 1'b1;
      end
      r.err = (r.mask != 0);
      return r;
   endfunction

   // Accept watcher: records the expected result of every accepted word.
   always @(posedge clk) begin
      cyc++;
      if (rst_n && in_valid && in_ready) begin
         if (b2b && last_acc >= 0) check("b2b_spacing", 64'(cyc - last_acc), 64'(DIGITS + 2));
         last_acc = cyc;
         exp_q.push_back(ref_conv(in_data));
         acc_q.push_back(cyc);
         n_acc++;
      end
   end

   // Monitor: latency, hold stability and result comparison on each handshake.
   logic              prev_hold = 1'b0;
   logic [W-1:0]      prev_bcd;
   logic [DIGITS-1:0] prev_mask;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (out_valid) begin
            check("valid_without_accept", 64'(acc_q.size() == 0), 64'(0));
            if (!prev_hold && acc_q.size() != 0)
               check("latency", 64'(cyc - acc_q[0]), 64'(DIGITS));
            if (prev_hold) begin
               check("hold_bcd", 64'(out_bcd), 64'(prev_bcd));
               check("hold_mask", 64'(out_err_mask), 64'(prev_mask));
            end
            check("in_ready_while_valid", 64'(in_ready), 64'(0));
            if (out_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               void'(acc_q.pop_front());
               check("out_bcd", 64'(out_bcd), 64'(e.bcd));
               check("out_err_mask", 64'(out_err_mask), 64'(e.mask));
               check("out_err", 64'(out_err), 64'(e.err));
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_bcd  = out_bcd;
         prev_mask = out_err_mask;
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_out_bcd"}, 64'(out_bcd), 64'(0));
      check({tag, "_mask"}, 64'(out_err_mask), 64'(0));
      check({tag, "_out_err"}, 64'(out_err), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
   endtask

   // Call away from a rising edge; returns 1 time unit after the accept edge.
   task automatic send(input logic [W-1:0] w);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("send_wait", 64'(n < 200), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int na;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #3;
      check_reset_vals("por");
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed words, including boundary and illegal codes.
      out_ready = 1'b1;
      send(16'h4C83);
      send(16'h3333);
      send(16'hCCCC);
      send(16'h3D36);
      send(16'h0000);
      send(16'hFEDC);
      wait_drain(100);

      // Backpressure: result held for 10 cycles, second word waits.
      out_ready = 1'b0;
      send(16'h7A5B);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 16'h9C43;
      na       = n_acc;
      repeat (10) begin
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'(0));
         check("bp_valid_held", 64'(out_valid), 64'(1));
      end
      check("bp_no_accept", 64'(n_acc), 64'(na));
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_in_ready_after", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_second_accept", 64'(n_acc), 64'(na + 1));
      wait_drain(100);

      // Reset two cycles into a conversion aborts the word.
      send(16'h5678);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_no_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      send(16'h9A4B);
      wait_drain(100);

      // Back-to-back with in_valid held high and data changing every cycle.
      out_ready = 1'b1;
      last_acc  = -1;
      b2b       = 1'b1;
      na        = n_acc;
      in_valid  = 1'b1;
      n         = 0;
      while (n_acc < na + 8 && n < 8 * (DIGITS + 2) + 20) begin
         in_data = W'($urandom);
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      check("b2b_count", 64'(n_acc), 64'(na + 8));
      wait_drain(100);
      b2b = 1'b0;

      // Random words, random gaps, random downstream backpressure.
      rnd_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send(W'($urandom));
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_drain(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xs3_bcd_seq.md
# xs3_bcd_seq

Sequenced multi-digit Excess-3 to BCD converter.
- Accepts a packed word of DIGITS Excess-3 digits over a valid/ready handshake.
- Converts one digit per clock through a single shared 4-bit digit converter.
- Flags any illegal Excess-3 codes.
- Returns the packed BCD result over a second valid/ready handshake.
- Sits between a serial/parallel front end that delivers Excess-3 words and any downstream BCD consumer (display driver, BCD arithmetic).

## Interface
- DIGITS, default 4: number of 4-bit digits per word; legal range 1..8.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: upstream word available.
- in_ready  output  1: block can accept a word; equals (state == IDLE).
- in_data  input  4*DIGITS: Excess-3 word; digit k occupies [4k+3:4k], digit 0 least significant.
- out_valid  output  1: result available; held until accepted.
- out_ready  input  1: downstream accepts the result.
- out_bcd  output  4*DIGITS: BCD result, same digit packing as in_data.
- out_err_mask  output  DIGITS: bit k set when input digit k was an illegal code.
- out_err  output  1: OR of out_err_mask.
- busy  output  1: high in CONV and DONE.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On the edge where in_valid && in_ready, capture in_data into the shift register, clear the result and mask registers, set idx=0, go to CONV.
  - CONV: each cycle, convert captured digit idx and write the result into out_bcd digit idx and out_err_mask bit idx. Increment idx. After the edge that processes idx=DIGITS-1, go to DONE.
  - DONE: out_valid=1. out_bcd, out_err_mask and out_err are stable. On out_valid && out_ready, go to IDLE.
- Digit conversion:
  - Legal code e in 3..12: BCD digit = e - 3 (4-bit subtraction), mask bit = 0.
  - Illegal code e in {0, 1, 2, 13, 14, 15}: BCD digit forced to 4'h0, mask bit = 1.
- idx counter width: clog2(DIGITS), minimum 1 bit. It does not wrap within a word; it is reloaded to 0 on accept.
- in_data is sampled only on the accept edge; later changes to it have no effect.
- There is no accept path in CONV or DONE. An upstream in_valid simply waits.
- out_valid never drops without a handshake, and the outputs never change while out_valid=1.
- out_ready is ignored outside DONE.

## Timing
- Reset values (asynchronous, immediate while rst_n=0):
  - state=IDLE, idx=0
  - out_valid=0, out_bcd=0, out_err_mask=0, out_err=0, busy=0
  - in_ready=1
- Latency: accept on edge T. Digits convert on edges T+1..T+DIGITS. out_valid is high from edge T+DIGITS.
- Minimum period per word is DIGITS+2 cycles: accept, DIGITS conversions, output handshake, IDLE.
- With out_ready held high, out_valid is high for exactly one cycle.
- in_ready returns high the cycle after the output handshake edge.
- Reset asserted mid-CONV or in DONE aborts the word. The partial result is discarded and not delivered. After release, the first accept behaves as from cold reset.
- DIGITS=1: CONV lasts exactly one cycle.

## Test plan
- Legal word, DIGITS=4: in_data=16'h4C83 with out_ready=1. Expect out_bcd=16'h1950, out_err_mask=4'b0000, out_err=0, out_valid exactly 4 cycles after accept.
- Boundary codes: 16'h3333 gives 16'h0000. 16'hCCCC gives 16'h9999. Both with mask 0.
- Illegal digits: 16'h3D36 gives out_bcd=16'h0003, mask=4'b0100, out_err=1. 16'h0000 gives out_bcd=0, mask=4'b1111.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Expect out_valid, out_bcd and mask stable, in_ready=0, and a second in_valid word not accepted. Raise out_ready: handshake occurs, in_ready=1 next cycle, second word accepted and converted correctly.
- Mid-operation reset: pulse rst_n low 2 cycles after accepting 16'h5678. Expect all outputs at reset values immediately, no out_valid afterwards. A following word 16'h9A4B converts to 16'h6718.
- Back-to-back with out_ready=1 and in_valid held high: accept spacing is exactly DIGITS+2 cycles and each result matches its own input.
